// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared VGA geometry defaults and helpers
// 640x480@60 defaults, polarity encoding and line/frame length helpers.
package vga_timing_pkg;

  localparam int CNT_W = 11;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam int DEF_H_FRONT = 16;
  localparam int DEF_H_SYNC  = 96;
  localparam int DEF_H_BACK  = 48;
  localparam int DEF_H_ACT   = 640;
  localparam int DEF_V_FRONT = 10;
  localparam int DEF_V_SYNC  = 2;
  localparam int DEF_V_BACK  = 33;
  localparam int DEF_V_ACT   = 480;
  localparam int DEF_COLOR_W = 10;
  localparam int DEF_PIX_LAT = 2;

  localparam logic POL_LOW = 1'b0;

  function automatic int totalLen(input int front, input int sync, input int back, input int act);
    return front + sync + back + act;
  endfunction

  function automatic int blankLen(input int front, input int sync, input int back);
    return front + sync + back;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - fixed-depth register pipeline with async and sync clear
// DEPTH=0 degenerates to a plain wire.
module vga_delay_line #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 2
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic             iClr,
  input  logic [WIDTH-1:0] iData,
  output logic [WIDTH-1:0] oData
);

  generate
    if (DEPTH == 0) begin : gWire
      logic unusedInputs;
      assign unusedInputs = ^{iCLK, iRST_N, iClr};
      assign oData = iData;
    end else begin : gPipe
      logic [WIDTH-1:0] stage [DEPTH];

      always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else if (iClr) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
          stage[0] <= iData;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign oData = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA timing generator and pixel-output stage
// Sync/blank are delayed by PIX_LAT so they line up with the host's late colour.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_FRONT = DEF_H_FRONT,
  parameter int   H_SYNC  = DEF_H_SYNC,
  parameter int   H_BACK  = DEF_H_BACK,
  parameter int   H_ACT   = DEF_H_ACT,
  parameter int   V_FRONT = DEF_V_FRONT,
  parameter int   V_SYNC  = DEF_V_SYNC,
  parameter int   V_BACK  = DEF_V_BACK,
  parameter int   V_ACT   = DEF_V_ACT,
  parameter logic H_POL   = POL_LOW,
  parameter logic V_POL   = POL_LOW,
  parameter int   COLOR_W = DEF_COLOR_W,
  parameter int   PIX_LAT = DEF_PIX_LAT
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic               iEN,
  input  logic [COLOR_W-1:0] iRed,
  input  logic [COLOR_W-1:0] iGreen,
  input  logic [COLOR_W-1:0] iBlue,
  output logic               oReq,
  output logic [10:0]        oCurrent_X,
  output logic [10:0]        oCurrent_Y,
  output logic               oLine_Start,
  output logic               oFrame_Start,
  output logic [COLOR_W-1:0] oVGA_R,
  output logic [COLOR_W-1:0] oVGA_G,
  output logic [COLOR_W-1:0] oVGA_B,
  output logic               oVGA_HS,
  output logic               oVGA_VS,
  output logic               oVGA_BLANK,
  output logic               oVGA_SYNC,
  output logic               oVGA_CLOCK
);

  localparam int H_TOTAL = totalLen(H_FRONT, H_SYNC, H_BACK, H_ACT);
  localparam int V_TOTAL = totalLen(V_FRONT, V_SYNC, V_BACK, V_ACT);

  localparam cnt_t H_LAST = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_BLK  = cnt_t'(blankLen(H_FRONT, H_SYNC, H_BACK));
  localparam cnt_t V_BLK  = cnt_t'(blankLen(V_FRONT, V_SYNC, V_BACK));
  localparam cnt_t HS_BEG = cnt_t'(H_FRONT);
  localparam cnt_t HS_END = cnt_t'(H_FRONT + H_SYNC);
  localparam cnt_t VS_BEG = cnt_t'(V_FRONT);
  localparam cnt_t VS_END = cnt_t'(V_FRONT + V_SYNC);

  cnt_t hCont, vCont;
  logic hsRaw, vsRaw;
  logic [2:0] dly;

  // Vertical advances on the last pixel clock of a line, not on an HS edge.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      hCont <= '0;
      vCont <= '0;
    end else if (!iEN) begin
      hCont <= '0;
      vCont <= '0;
    end else if (hCont == H_LAST) begin
      hCont <= '0;
      vCont <= (vCont == V_LAST) ? cnt_t'(0) : vCont + cnt_t'(1);
    end else begin
      hCont <= hCont + cnt_t'(1);
    end
  end

  always_comb begin
    oReq         = (hCont >= H_BLK) && (vCont >= V_BLK);
    oCurrent_X   = oReq ? hCont - H_BLK : '0;
    oCurrent_Y   = oReq ? vCont - V_BLK : '0;
    oLine_Start  = oReq && (oCurrent_X == '0);
    oFrame_Start = oLine_Start && (oCurrent_Y == '0);
  end

  assign hsRaw = (hCont >= HS_BEG) && (hCont < HS_END);
  assign vsRaw = (vCont >= VS_BEG) && (vCont < VS_END);

  vga_delay_line #(
    .WIDTH(3),
    .DEPTH(PIX_LAT)
  ) uDelay (
    .iCLK  (iCLK),
    .iRST_N(iRST_N),
    .iClr  (!iEN),
    .iData ({hsRaw, vsRaw, oReq}),
    .oData (dly)
  );

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oVGA_HS    <= ~H_POL;
      oVGA_VS    <= ~V_POL;
      oVGA_BLANK <= 1'b0;
      oVGA_R     <= '0;
      oVGA_G     <= '0;
      oVGA_B     <= '0;
    end else if (!iEN) begin
      oVGA_HS    <= ~H_POL;
      oVGA_VS    <= ~V_POL;
      oVGA_BLANK <= 1'b0;
      oVGA_R     <= '0;
      oVGA_G     <= '0;
      oVGA_B     <= '0;
    end else begin
      oVGA_HS    <= dly[2] ? H_POL : ~H_POL;
      oVGA_VS    <= dly[1] ? V_POL : ~V_POL;
      oVGA_BLANK <= dly[0];
      oVGA_R     <= dly[0] ? iRed   : '0;
      oVGA_G     <= dly[0] ? iGreen : '0;
      oVGA_B     <= dly[0] ? iBlue  : '0;
    end
  end

  assign oVGA_SYNC  = 1'b1;
  assign oVGA_CLOCK = ~iCLK;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised, single-clock VGA timing generator and pixel-output stage. It is the successor to the fixed 640x480 controller: the vertical counter runs on the pixel clock rather than on the HS edge, sync polarity and geometry are parameters, and a configurable host-colour latency is absorbed by delaying sync/blank. It sits between the frame renderer, which answers pixel requests, and the VGA DAC pins.

## Interface
Parameters:
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width
- H_BACK, 48, horizontal back porch
- H_ACT, 640, active pixels per line
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BACK, 33, vertical back porch
- V_ACT, 480, active lines
- H_POL, 0, HS active level (0 = active-low)
- V_POL, 0, VS active level
- COLOR_W, 10, bits per colour channel
- PIX_LAT, 2, host colour latency in cycles after oReq (0..7)

Ports:
- iCLK  in  1  pixel clock
- iRST_N  in  1  asynchronous active-low reset
- iEN  in  1  timing enable; low = counters held at 0
- iRed, iGreen, iBlue  in  COLOR_W  host colour, valid PIX_LAT cycles after the matching oReq
- oReq  out  1  pixel request (active region)
- oCurrent_X  out  11  requested column, 0 outside active region
- oCurrent_Y  out  11  requested row, 0 outside active region
- oLine_Start  out  1  one-cycle pulse with first oReq of each active line
- oFrame_Start  out  1  one-cycle pulse with oReq at X=0, Y=0
- oVGA_R, oVGA_G, oVGA_B  out  COLOR_W  DAC colour
- oVGA_HS, oVGA_VS  out  1  sync
- oVGA_BLANK  out  1  high = active video
- oVGA_SYNC  out  1  constant 1
- oVGA_CLOCK  out  1  ~iCLK

## Operation
- H_TOTAL = H_FRONT+H_SYNC+H_BACK+H_ACT; V_TOTAL likewise; H_BLANK/V_BLANK = front+sync+back. Line order: front, sync, back, active.
- H_Cont counts 0..H_TOTAL-1, wraps to 0. V_Cont increments when H_Cont = H_TOTAL-1, wraps to 0 after V_TOTAL-1. Both 11-bit registers.
- Request stage (combinational from counters): oReq = (H_Cont ≥ H_BLANK) && (V_Cont ≥ V_BLANK); X = H_Cont−H_BLANK, Y = V_Cont−V_BLANK when oReq, else 0. oLine_Start = oReq && X=0; oFrame_Start = oLine_Start && Y=0.
- Raw HS active when H_FRONT ≤ H_Cont < H_FRONT+H_SYNC; raw VS active when V_FRONT ≤ V_Cont < V_FRONT+V_SYNC (whole lines, changes only at H_Cont = 0). Active level per H_POL/V_POL.
- Raw HS, VS, oReq pass through a PIX_LAT-deep delay line, then one output register. Colour register captures iRed/iGreen/iBlue when delayed oReq is high, else loads 0. Every pixel including X=0 is shown.
- iEN low: counters synchronously forced to 0, delay line cleared, outputs go to reset values next edge. iEN rising: frame restarts at H=0, V=0.

## Timing
- Reset (async) values: counters 0, oVGA_HS = ~H_POL, oVGA_VS = ~V_POL, oVGA_BLANK 0, colours 0, delay line 0. Request outputs follow counters (oReq 0).
- First edge after reset release: H_Cont 0→1. oReq first high when H_Cont = H_BLANK, V_Cont = V_BLANK.
- oVGA_* lag request stage by exactly PIX_LAT+1 cycles; HS/VS/BLANK/colour mutually aligned.
- Default line 800 cycles, frame 420 000 cycles; HS low 96 cycles/line; VS low 1600 cycles/frame.
- Reset mid-frame: all state cleared immediately, no partial sync pulse completes.

## Structure
- Package vga_timing_pkg: 640x480@60 default constants, polarity constants, total/blank helper functions.
- Sub-module vga_delay_line (parameters WIDTH, DEPTH; DEPTH=0 is a wire; async active-low clear plus sync clear) carries {HS, VS, req}.

## Test plan
- Default params, PIX_LAT=2: HS period 800, low 96 cycles starting at H_Cont=16 + 3 cycle lag; VS low for 1600 cycles, period 420 000.
- Host returns colour = X: oVGA_R equals 0..639 on consecutive active cycles, first value 0 with oVGA_BLANK rising same cycle; R=0 during blanking.
- PIX_LAT=0 and PIX_LAT=7: colour-to-BLANK alignment holds; output lag 1 and 8 cycles respectively.
- H_POL=1, V_POL=1, 800x600 geometry (40/128/88/800, 1/4/23/600): sync pulses high, widths 128 cycles and 4 lines, oFrame_Start once per 1056×628 cycles.
- iRST_N asserted mid-line at H_Cont=300: outputs at reset values without a clock edge; after release oReq first high 45×800+160 cycles later.
- iEN low for 50 cycles mid-frame: no oReq, HS inactive; after iEN high, oFrame_Start after 36 160 cycles.
